branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor with a target buffer for the 5-stage MIPS pipeline.
- Replaces the resolve-in-ID-and-redirect scheme, which always fetches PC+4.
- The IF stage looks up the current PC each cycle and gets a predicted next PC.
- The ID stage reports resolved branches/jumps back. The block updates its direct-mapped table of saturating counters and targets, and flags mispredictions with the correct redirect PC.

---
 rtl/branch_predictor_pkg.sv | 30 +++
 rtl/bp_sat_counter.sv | 55 +++++
 rtl/branch_predictor.sv | 170 +++++++++++++++++
 tb/tb_branch_predictor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_predictor_pkg: shared constants, update-action type and helpers    |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
package branch_predictor_pkg;

  localparam int PC_INC = 4;

  typedef enum logic [1:0] {
    UPD_NONE  = 2'd0,
    UPD_HIT   = 2'd1,
    UPD_ALLOC = 2'd2
  } upd_action_e;

  // Counter encodings; the MSB of the counter is the taken/not-taken decision.
  function automatic int cnt_weak_t(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction

  function automatic int cnt_weak_nt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction

  function automatic int cnt_max(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage : branch_predictor_pkg
`default_nettype wire

// File: rtl/bp_sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bp_sat_counter: up/down saturating counter with init/max/weak-taken loads |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module bp_sat_counter
  import branch_predictor_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_en,
  input  logic             load_max,
  input  logic             load_wt,
  input  logic             step_en,
  input  logic             step_up,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] c_cnt_wt   = CNT_W'(cnt_weak_t(CNT_W));
  localparam logic [CNT_W-1:0] c_cnt_wnt  = CNT_W'(cnt_weak_nt(CNT_W));
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load priority: init (flush) beats any same-cycle update.
  always_comb begin
    cnt_d = cnt_q;
    if (init_en) begin
      cnt_d = c_cnt_wnt;
    end else if (load_max) begin
      cnt_d = c_cnt_max;
    end else if (load_wt) begin
      cnt_d = c_cnt_wt;
    end else if (step_en) begin
      if (step_up) begin
        if (cnt_q != c_cnt_max) cnt_d = cnt_q + c_cnt_one;
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - c_cnt_one;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= c_cnt_wnt;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule : bp_sat_counter
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | branch_predictor: direct-mapped counter/target table for IF prediction    |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            cpu_rst_n,
  input  logic            cpu_en,
  input  logic            flush_all,
  input  logic            lookup_en,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] c_pc_inc = XLEN'(PC_INC);

  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [XLEN-1:0]  target_d [ENTRIES];
  logic             jump_q   [ENTRIES];
  logic             jump_d   [ENTRIES];
  logic [CNT_W-1:0] cnt_val  [ENTRIES];

  logic [ENTRIES-1:0] cnt_load_max;
  logic [ENTRIES-1:0] cnt_load_wt;
  logic [ENTRIES-1:0] cnt_step;

  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit;
  logic             do_upd;
  logic             do_flush;
  upd_action_e      upd_action;

  assign lk_idx  = if_pc[IDX_W+1:2];
  assign lk_tag  = if_pc[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[XLEN-1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && (jump_q[lk_idx] || cnt_val[lk_idx][CNT_W-1]);
  assign pred_target = pred_taken ? target_q[lk_idx] : (if_pc + c_pc_inc);

  assign mispredict  = upd_valid &&
                       ((upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = !upd_valid ? '0 :
                       (upd_taken ? upd_target : (upd_pc + c_pc_inc));

  assign do_flush = cpu_en && flush_all;
  assign do_upd   = cpu_en && upd_valid && !flush_all;
  assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  always_comb begin
    upd_action = UPD_NONE;
    if (do_upd) begin
      if (upd_hit)        upd_action = UPD_HIT;
      else if (upd_taken) upd_action = UPD_ALLOC;
    end
  end

  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    target_d     = target_q;
    jump_d       = jump_q;
    cnt_load_max = '0;
    cnt_load_wt  = '0;
    cnt_step     = '0;
    if (do_flush) begin
      for (int i = 0; i < ENTRIES; i++) valid_d[i] = 1'b0;
    end else begin
      case (upd_action)
        UPD_HIT: begin
          if (upd_taken) target_d[upd_idx] = upd_target;
          jump_d[upd_idx]       = upd_is_jump;
          cnt_load_max[upd_idx] = upd_is_jump;
          cnt_step[upd_idx]     = !upd_is_jump;
        end
        UPD_ALLOC: begin
          valid_d[upd_idx]      = 1'b1;
          tag_d[upd_idx]        = upd_tag;
          target_d[upd_idx]     = upd_target;
          jump_d[upd_idx]       = upd_is_jump;
          cnt_load_max[upd_idx] = upd_is_jump;
          cnt_load_wt[upd_idx]  = !upd_is_jump;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stat_lookups_d     = stat_lookups_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (cpu_en && lookup_en && (stat_lookups_q != '1))
      stat_lookups_d = stat_lookups_q + 32'd1;
    if (cpu_en && mispredict && (stat_mispredicts_q != '1))
      stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jump_q[i]   <= 1'b0;
      end
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      jump_q             <= jump_d;
      stat_lookups_q     <= stat_lookups_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    bp_sat_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (cpu_rst_n),
      .init_en  (do_flush),
      .load_max (cnt_load_max[gi]),
      .load_wt  (cnt_load_wt[gi]),
      .step_en  (cnt_step[gi]),
      .step_up  (upd_taken),
      .cnt      (cnt_val[gi])
    );
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_branch_predictor: directed self-checking bench for branch_predictor    |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_branch_predictor;

  logic        clk;
  logic        cpu_rst_n;
  logic        cpu_en;
  logic        flush_all;
  logic        lookup_en;
  logic [31:0] if_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .XLEN    (32),
    .ENTRIES (16),
    .CNT_W   (2)
  ) dut (
    .clk              (clk),
    .cpu_rst_n        (cpu_rst_n),
    .cpu_en           (cpu_en),
    .flush_all        (flush_all),
    .lookup_en        (lookup_en),
    .if_pc            (if_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_is_jump      (upd_is_jump),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_pred_taken   (upd_pred_taken),
    .upd_pred_target  (upd_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic ptaken, input logic [31:0] ptgt, input logic jmp);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_taken       = taken;
    upd_target      = tgt;
    upd_pred_taken  = ptaken;
    upd_pred_target = ptgt;
    upd_is_jump     = jmp;
  endtask

  task automatic no_upd;
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
    upd_is_jump     = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic tkn, input logic [31:0] tgt);
    if_pc = pc;
    settle();
    chk({tag, "_hit"}, {31'd0, pred_hit}, {31'd0, hit});
    chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tkn});
    chk({tag, "_target"}, pred_target, tgt);
  endtask

  initial begin
    cpu_rst_n = 1'b0;
    cpu_en    = 1'b1;
    flush_all = 1'b0;
    lookup_en = 1'b0;
    if_pc     = 32'h100;
    no_upd();
    #12;
    cpu_rst_n = 1'b1;
    settle();

    // Reset state
    look("rst", 32'h100, 1'b0, 1'b0, 32'h104);
    chk("rst_lookups", stat_lookups, 32'd0);
    chk("rst_mispredicts", stat_mispredicts, 32'd0);
    chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
    tick();

    // Allocate 0x100 taken -> 0x200; lookup in the same cycle sees old contents
    lookup_en = 1'b1;
    set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0);
    look("alloc_same", 32'h100, 1'b0, 1'b0, 32'h104);
    chk("alloc_mis", {31'd0, mispredict}, 32'd1);
    chk("alloc_redir", redirect_pc, 32'h200);
    tick();
    lookup_en = 1'b0;
    no_upd();
    look("alloc_next", 32'h100, 1'b1, 1'b1, 32'h200);
    chk("alloc_lookups", stat_lookups, 32'd1);
    chk("alloc_mispredicts", stat_mispredicts, 32'd1);

    // Hysteresis: 10 -> 01 -> 00 -> 00, then taken -> 01, taken -> 10
    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    settle();
    chk("nt1_mis", {31'd0, mispredict}, 32'd1);
    chk("nt1_redir", redirect_pc, 32'h104);
    tick();
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
    set_upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0);
    settle();
    chk("nt2_mis", {31'd0, mispredict}, 32'd0);
    tick();
    look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
    tick();
    look("nt3", 32'h100, 1'b1, 1'b0, 32'h104);
    set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104, 1'b0);
    tick();
    look("t1", 32'h100, 1'b1, 1'b0, 32'h104);
    tick();
    look("t2", 32'h100, 1'b1, 1'b1, 32'h200);
    chk("t2_mispredicts", stat_mispredicts, 32'd4);

    // Upper saturation: 10 -> 11 -> 11, then one not-taken -> 10 still taken
    set_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
    settle();
    chk("sat_hi_mis", {31'd0, mispredict}, 32'd0);
    tick();
    tick();
    set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b0);
    tick();
    no_upd();
    look("sat_hi", 32'h100, 1'b1, 1'b1, 32'h200);
    chk("sat_hi_mispredicts", stat_mispredicts, 32'd5);

    // Aliasing: 0x140 shares index 0 with 0x100
    set_upd(32'h140, 1'b1, 32'h400, 1'b0, 32'h144, 1'b0);
    tick();
    no_upd();
    look("alias_new", 32'h140, 1'b1, 1'b1, 32'h400);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);

    // Jump allocates with counter at max: a later not-taken leaves it taken
    set_upd(32'h184, 1'b1, 32'h800, 1'b1, 32'h800, 1'b1);
    settle();
    chk("jmp_mis", {31'd0, mispredict}, 32'd0);
    tick();
    look("jmp", 32'h184, 1'b1, 1'b1, 32'h800);
    set_upd(32'h184, 1'b0, 32'h0, 1'b1, 32'h800, 1'b0);
    tick();
    no_upd();
    look("jmp_nt", 32'h184, 1'b1, 1'b1, 32'h800);

    // Target mismatch with correct direction still mispredicts
    set_upd(32'h140, 1'b1, 32'h440, 1'b1, 32'h400, 1'b0);
    settle();
    chk("tgt_mis", {31'd0, mispredict}, 32'd1);
    chk("tgt_redir", redirect_pc, 32'h440);
    tick();
    no_upd();
    look("tgt", 32'h140, 1'b1, 1'b1, 32'h440);
    chk("tgt_mispredicts", stat_mispredicts, 32'd8);

    // cpu_en = 0 freezes table and statistics, outputs stay live
    cpu_en    = 1'b0;
    lookup_en = 1'b1;
    set_upd(32'h140, 1'b0, 32'h0, 1'b1, 32'h440, 1'b0);
    settle();
    chk("dis_mis", {31'd0, mispredict}, 32'd1);
    tick();
    tick();
    cpu_en    = 1'b1;
    lookup_en = 1'b0;
    no_upd();
    look("dis", 32'h140, 1'b1, 1'b1, 32'h440);
    chk("dis_lookups", stat_lookups, 32'd1);
    chk("dis_mispredicts", stat_mispredicts, 32'd8);

    // Flush beats a same-cycle allocation but the misprediction still counts
    flush_all = 1'b1;
    set_upd(32'h300, 1'b1, 32'h900, 1'b0, 32'h304, 1'b0);
    tick();
    flush_all = 1'b0;
    no_upd();
    look("fl_300", 32'h300, 1'b0, 1'b0, 32'h304);
    look("fl_140", 32'h140, 1'b0, 1'b0, 32'h144);
    look("fl_184", 32'h184, 1'b0, 1'b0, 32'h188);
    chk("fl_mispredicts", stat_mispredicts, 32'd9);
    chk("fl_lookups", stat_lookups, 32'd1);

    // Re-populate, then pulse reset mid-cycle
    lookup_en = 1'b1;
    set_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0);
    tick();
    lookup_en = 1'b0;
    no_upd();
    look("pre_rst", 32'h100, 1'b1, 1'b1, 32'h200);
    chk("pre_rst_lookups", stat_lookups, 32'd2);
    cpu_rst_n = 1'b0;
    look("mid_rst", 32'h100, 1'b0, 1'b0, 32'h104);
    chk("mid_rst_lookups", stat_lookups, 32'd0);
    chk("mid_rst_mispredicts", stat_mispredicts, 32'd0);
    cpu_rst_n = 1'b1;
    tick();
    look("post_rst", 32'h100, 1'b0, 1'b0, 32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_branch_predictor
`default_nettype wire
